// File: rtl/pool_plane_writer_pkg.sv
// pool_plane_writer_pkg
// Shared constants and types for the layer-1 mid-buffer write-back path.
// The channel buffer on the read side uses the same geometry constants, so the
// flat layout addr = ch*PLANE + row*OUT_W + col is defined in one place.
package pool_plane_writer_pkg;

  localparam int CH    = 32;                   // channels per input beat
  localparam int OUT_H = 17;                   // pooled rows
  localparam int OUT_W = 13;                   // pooled columns
  localparam int DW    = 32;                   // word width
  localparam int PLANE = OUT_H * OUT_W;        // words per channel plane (221)
  localparam int AW    = $clog2(CH * PLANE);   // flat address width (13)
  localparam int ROW_W = $clog2(OUT_H);
  localparam int COL_W = $clog2(OUT_W);
  localparam int POS_W = $clog2(PLANE);
  localparam int CH_W  = $clog2(CH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IN,
    SERIAL,
    DONE
  } state_t;

endpackage

// File: rtl/pool_plane_writer_pos_counter.sv
// pool_plane_writer_pos_counter
// Row/column scan counter over a ROWS x COLS plane. Keeps a linear index in
// step with row/col so users get row*COLS+col without a multiplier.
// Holds at the last position: inc is ignored once last is high.
//
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   clr   in   return to position (0,0)
//   inc   in   advance one position (col first, row on col wrap)
//   row   out  current row
//   col   out  current column
//   pos   out  linear index row*COLS+col
//   last  out  high at (ROWS-1, COLS-1)
module pool_plane_writer_pos_counter
  import pool_plane_writer_pkg::*;
#(
  parameter  int ROWS = OUT_H,
  parameter  int COLS = OUT_W,
  localparam int RW   = $clog2(ROWS),
  localparam int CW   = $clog2(COLS),
  localparam int PW   = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [PW-1:0] pos,
  output logic          last
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
      pos <= '0;
    end else if (inc && !last) begin
      pos <= pos + 1'b1;
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_plane_writer.sv
// pool_plane_writer
// Takes one pooled spatial position per handshake (CH channel words in
// parallel) and writes them out one word per cycle into a flat channel-major
// memory: addr = ch*PLANE + row*OUT_W + col. Pulses done after the last word
// of the whole CH x OUT_H x OUT_W set has been accepted by the memory.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   start    in   begin a frame (only looked at in IDLE)
//   valid_in in   data_in holds one pooled position
//   in_ready out  block accepts data_in this cycle
//   data_in  in   channel c at bits [c*DW +: DW]
//   wr_en    out  write strobe
//   wr_addr  out  flat word address
//   wr_data  out  write word
//   wr_ready in   memory accepts the write this cycle
//   busy     out  high outside IDLE
//   done     out  one-cycle pulse after the final write completes
//
// State    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; no writes
// WAIT_IN  | in_ready high, waiting for the next pooled position
// SERIAL   | writing staged words ch = 0..CH-1 for the current position
// DONE     | one-cycle done pulse, then back to IDLE
module pool_plane_writer
  import pool_plane_writer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid_in,
  output logic             in_ready,
  input  logic [CH*DW-1:0] data_in,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  input  logic             wr_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0]   PLANE_A = AW'(PLANE);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH - 1);

  state_t           state;
  logic [CH_W-1:0]  ch;
  logic [CH_W-1:0]  ch_nxt;
  logic [AW-1:0]    base;      // ch*PLANE, kept as a running sum
  logic [AW-1:0]    base_nxt;
  logic [DW-1:0]    stage [CH];

  logic [ROW_W-1:0] pc_row;
  logic [COL_W-1:0] pc_col;
  logic [POS_W-1:0] pos;
  logic             pos_last;
  logic [AW-1:0]    pos_ext;
  logic             wr_fire;
  logic             pos_clr;
  logic             pos_inc;
  logic             unused_rc;

  assign ch_nxt   = ch + 1'b1;
  assign base_nxt = base + PLANE_A;
  assign pos_ext  = {{(AW - POS_W){1'b0}}, pos};

  // wr_en is always high in SERIAL, so a write completes on wr_ready alone.
  assign wr_fire = (state == SERIAL) && wr_ready;
  assign pos_clr = (state == IDLE) && start;
  assign pos_inc = wr_fire && (ch == CH_LAST) && !pos_last;

  // Row/col are only needed by the read-side scanner; here the linear index suffices.
  assign unused_rc = ^{pc_row, pc_col};

  pool_plane_writer_pos_counter #(
    .ROWS (OUT_H),
    .COLS (OUT_W)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pos_clr),
    .inc   (pos_inc),
    .row   (pc_row),
    .col   (pc_col),
    .pos   (pos),
    .last  (pos_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch       <= '0;
      base     <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        stage[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ch       <= '0;
            base     <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= WAIT_IN;
          end
        end

        WAIT_IN: begin
          if (valid_in && in_ready) begin
            for (int c = 0; c < CH; c++) begin
              stage[c] <= data_in[c*DW +: DW];
            end
            // Channel 0 is presented straight from data_in so the first
            // write appears the cycle after the handshake.
            ch       <= '0;
            base     <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b1;
            wr_addr  <= pos_ext;
            wr_data  <= data_in[DW-1:0];
            state    <= SERIAL;
          end
        end

        SERIAL: begin
          if (wr_ready) begin
            if (ch == CH_LAST) begin
              ch    <= '0;
              base  <= '0;
              wr_en <= 1'b0;
              if (pos_last) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                in_ready <= 1'b1;
                state    <= WAIT_IN;
              end
            end else begin
              ch      <= ch_nxt;
              base    <= base_nxt;
              wr_addr <= base_nxt + pos_ext;
              wr_data <= stage[ch_nxt];
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_plane_writer.sv
// tb_pool_plane_writer
// Scoreboard bench for pool_plane_writer: beats push their expected writes
// into a queue, an independent monitor pops one entry per completed write.
module tb_pool_plane_writer;
  import pool_plane_writer_pkg::*;

  localparam int NW = CH * PLANE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             valid_in = 1'b0;
  logic             in_ready;
  logic [CH*DW-1:0] data_in = '0;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             wr_ready = 1'b1;
  logic             busy;
  logic             done;

  pool_plane_writer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .valid_in (valid_in),
    .in_ready (in_ready),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [NW];
  int          wcnt [NW];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          last_addr = 0;
  int          done_cnt = 0;
  bit          stall_en = 0;
  bit          noise_en = 0;
  bit          chk_en = 0;
  bit          stall_pend = 0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory-side handshake: random back-pressure when stall_en is set.
  always @(posedge clk) begin
    #1;
    wr_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (stall_pend) begin
        check("stall_wr_en_held", wr_en, 1);
        check("stall_addr_held", wr_addr, held_addr);
        check("stall_data_held", wr_data, held_data);
      end
      if (wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", wr_addr, '1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.a);
          check("wr_data", wr_data, e.d);
        end
        if (int'(wr_addr) < NW) begin
          mem[wr_addr]  = wr_data;
          wcnt[wr_addr] = wcnt[wr_addr] + 1;
        end
        last_addr   = int'(wr_addr);
        last_wr_cyc = cyc;
      end
      stall_pend = wr_en && !wr_ready;
      held_addr  = wr_addr;
      held_data  = wr_data;
      if (done) begin
        done_cnt++;
        check("done_after_last_write", cyc, last_wr_cyc + 1);
      end
    end else begin
      stall_pend = 0;
    end
  end

  function automatic logic [31:0] frame_word(input int c, input int p);
    logic [31:0] pv;
    logic [31:0] cv;
    pv = p;
    cv = c;
    return {pv[15:0], cv[15:0]};
  endfunction

  task automatic randomize_data();
    for (int c = 0; c < CH; c++) data_in[c*DW +: DW] = $urandom;
  endtask

  task automatic clear_model();
    for (int a = 0; a < NW; a++) begin
      mem[a]  = '0;
      wcnt[a] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    start    = 1'b0;
    valid_in = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start_frame(output int scyc);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    scyc = cyc;
  endtask

  // Present one pooled position p once in_ready is seen; while waiting,
  // optionally drive junk valid/data/start that the DUT must ignore.
  task automatic send_beat(input int p, input bit pattern1);
    int          n;
    logic [31:0] w [CH];
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      if (noise_en) begin
        valid_in = 1'b1;
        start    = 1'($urandom_range(0, 1));
        randomize_data();
      end else begin
        valid_in = 1'b0;
        start    = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", in_ready, 1);
      valid_in = 1'b0;
      start    = 1'b0;
      return;
    end
    start = 1'b0;
    for (int c = 0; c < CH; c++) begin
      w[c] = pattern1 ? (32'h100 + 32'(c)) : frame_word(c, p);
      data_in[c*DW +: DW] = w[c];
    end
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (noise_en) randomize_data();
    for (int c = 0; c < CH; c++) exp_q.push_back('{a: c * PLANE + p, d: w[c]});
    @(negedge clk);
    check("first_wr_en", wr_en, 1);
    check("first_wr_addr", wr_addr, p);
    check("in_ready_drop", in_ready, 0);
  endtask

  task automatic run_frame(input bit check_time, input bit noisy);
    int scyc;
    int n;
    int d0;
    int bad_cnt;
    int bad_dat;
    clear_model();
    d0 = done_cnt;
    start_frame(scyc);
    for (int p = 0; p < PLANE; p++) begin
      noise_en = noisy && (p > 0);
      send_beat(p, 1'b0);
    end
    noise_en = 0;
    valid_in = 1'b0;
    start    = 1'b0;
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    if (check_time) check("frame_cycles", cyc - scyc, PLANE * (CH + 1));
    check("last_addr", last_addr, NW - 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_low_after_done", busy, 0);
    check("done_pulses", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);
    bad_cnt = 0;
    bad_dat = 0;
    for (int a = 0; a < NW; a++) begin
      if (wcnt[a] != 1) bad_cnt++;
      if (mem[a] !== frame_word(a / PLANE, a % PLANE)) bad_dat++;
    end
    check("each_addr_once", bad_cnt, 0);
    check("mem_contents", bad_dat, 0);
  endtask

  initial begin
    int scyc;
    int bad;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Single beat with word c = 0x100+c.
    clear_model();
    start_frame(scyc);
    check("busy_after_start", busy, 1);
    send_beat(0, 1'b1);
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check("in_ready_return", in_ready, 1);
    check("wr_en_low_between", wr_en, 0);
    bad = 0;
    for (int c = 0; c < CH; c++) begin
      if (wcnt[c * PLANE] != 1 || mem[c * PLANE] !== 32'h100 + 32'(c)) bad++;
    end
    check("beat1_mem", bad, 0);
    do_reset();
    @(negedge clk);
    check_reset_outputs("reset2");

    // Full frame, no back-pressure.
    run_frame(1'b1, 1'b0);

    // Full frame with random stalls and junk start/valid during SERIAL.
    stall_en = 1;
    run_frame(1'b0, 1'b1);
    stall_en = 0;

    // Reset in the middle of beat 50, then a fresh frame.
    clear_model();
    start_frame(scyc);
    for (int p = 0; p <= 50; p++) send_beat(p, 1'b0);
    repeat (5) @(negedge clk);
    do_reset();
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (wr_en || busy || in_ready) bad++;
    end
    check("quiet_after_reset", bad, 0);
    run_frame(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
